// File: rtl/pixel_chunk_packer.sv
// Packs a serial pixel stream into CHUNK_SIZE-wide chunks for the upscaler chunk stage.
// Line-end partial chunks are padded by replicating the last pixel.
module pixel_chunk_packer #(
  parameter int PIXEL_W    = 24,
  parameter int CHUNK_SIZE = 8,
  parameter int X_W        = 8
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [PIXEL_W-1:0]               s_pixel,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic                             s_sof,
  input  logic                             s_eol,
  output logic [PIXEL_W*CHUNK_SIZE-1:0]    m_chunk,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [$clog2(CHUNK_SIZE+1)-1:0]  m_count,
  output logic                             m_sof,
  output logic                             m_eol,
  output logic [X_W-1:0]                   m_chunk_x,
  output logic                             drop_pulse
);

  localparam int IDX_W  = $clog2(CHUNK_SIZE);
  localparam int CNT_W  = $clog2(CHUNK_SIZE+1);
  localparam int DATA_W = PIXEL_W*CHUNK_SIZE;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNK_SIZE-1);

  logic [IDX_W-1:0]  idx_r;
  logic [DATA_W-1:0] acc_r;
  logic              sof_r;
  logic [X_W-1:0]    x_r;

  logic              accept_s;
  logic              mid_sof_s;
  logic              complete_s;
  logic [IDX_W-1:0]  eff_idx_s;
  logic [X_W-1:0]    eff_x_s;
  logic [DATA_W-1:0] chunk_s;

  assign s_ready = resetn && (!m_valid || m_ready);

  // A SOF beat restarts the chunk at lane 0; lanes at or above the current index take the pixel (padding).
  always_comb begin
    accept_s  = s_valid && s_ready;
    mid_sof_s = accept_s && s_sof && (idx_r != {IDX_W{1'b0}});
    if (s_sof) begin
      eff_idx_s = {IDX_W{1'b0}};
      eff_x_s   = {X_W{1'b0}};
    end else begin
      eff_idx_s = idx_r;
      eff_x_s   = x_r;
    end
    complete_s = accept_s && ((eff_idx_s == LAST_IDX) || s_eol);
    chunk_s    = {DATA_W{1'b0}};
    for (int i = 0; i < CHUNK_SIZE; i++) begin
      if (IDX_W'(i) < eff_idx_s) begin
        chunk_s[i*PIXEL_W +: PIXEL_W] = acc_r[i*PIXEL_W +: PIXEL_W];
      end else begin
        chunk_s[i*PIXEL_W +: PIXEL_W] = s_pixel;
      end
    end
  end

  // Accumulator, fill index, pending SOF flag and line chunk counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx_r <= {IDX_W{1'b0}};
      acc_r <= {DATA_W{1'b0}};
      sof_r <= 1'b0;
      x_r   <= {X_W{1'b0}};
    end else if (accept_s) begin
      acc_r <= chunk_s;
      if (complete_s) begin
        idx_r <= {IDX_W{1'b0}};
        sof_r <= 1'b0;
        x_r   <= s_eol ? {X_W{1'b0}} : (eff_x_s + X_W'(1));
      end else begin
        idx_r <= eff_idx_s + IDX_W'(1);
        sof_r <= sof_r | s_sof;
        x_r   <= eff_x_s;
      end
    end
  end

  // Output chunk register; a new chunk may load on the same edge the old one is taken.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_valid    <= 1'b0;
      m_chunk    <= {DATA_W{1'b0}};
      m_count    <= {CNT_W{1'b0}};
      m_sof      <= 1'b0;
      m_eol      <= 1'b0;
      m_chunk_x  <= {X_W{1'b0}};
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= mid_sof_s;
      if (complete_s) begin
        m_valid   <= 1'b1;
        m_chunk   <= chunk_s;
        m_count   <= CNT_W'(eff_idx_s) + CNT_W'(1);
        m_sof     <= sof_r | s_sof;
        m_eol     <= s_eol;
        m_chunk_x <= eff_x_s;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_chunk_packer.sv
// Self-checking bench for pixel_chunk_packer: directed table, hand sequences and a
// randomized run checked against a queue-based chunking model.
module tb_pixel_chunk_packer;

  localparam int PW = 24;
  localparam int CS = 8;
  localparam int XW = 8;

  logic          clk;
  logic          resetn;
  logic [PW-1:0] s_pixel;
  logic          s_valid, s_ready, s_sof, s_eol;
  logic [PW*CS-1:0] m_chunk;
  logic          m_valid, m_ready, m_sof, m_eol, drop_pulse;
  logic [3:0]    m_count;
  logic [XW-1:0] m_chunk_x;

  pixel_chunk_packer #(.PIXEL_W(PW), .CHUNK_SIZE(CS), .X_W(XW)) dut (
    .clk(clk), .resetn(resetn), .s_pixel(s_pixel), .s_valid(s_valid), .s_ready(s_ready),
    .s_sof(s_sof), .s_eol(s_eol), .m_chunk(m_chunk), .m_valid(m_valid), .m_ready(m_ready),
    .m_count(m_count), .m_sof(m_sof), .m_eol(m_eol), .m_chunk_x(m_chunk_x),
    .drop_pulse(drop_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending pixels of the current chunk, line state, and the held output chunk.
  logic [PW-1:0]    pend[$];
  bit               mf_sof;
  int               mf_x;
  bit               mo_v;
  logic [PW*CS-1:0] mo_chunk;
  int               mo_cnt;
  bit               mo_sof, mo_eol;
  int               mo_x;
  bit               me_drop;

  typedef struct {
    logic          v;
    logic [PW-1:0] pix;
    logic          sof, eol, mr;
    logic          ev;
    logic [3:0]    ecnt;
    logic          esof, eeol;
    logic [7:0]    ex;
    logic          edrop;
    logic [PW-1:0] el0, el7;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [PW*CS-1:0] act, input logic [PW*CS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    mf_sof = 1'b0; mf_x = 0; mo_v = 1'b0; me_drop = 1'b0;
  endtask

  task automatic model_edge(input logic acc, input logic [PW-1:0] pix, input logic sof,
                            input logic eol, input logic mr);
    bit hs;
    hs = mo_v && mr;
    me_drop = 1'b0;
    if (acc) begin
      if (sof && pend.size() != 0) begin
        pend.delete();
        me_drop = 1'b1;
      end
      if (sof) begin
        mf_x = 0;
        mf_sof = 1'b1;
      end
      pend.push_back(pix);
      if (pend.size() == CS || eol) begin
        for (int i = 0; i < CS; i++)
          mo_chunk[i*PW +: PW] = (i < pend.size()) ? pend[i] : pend[pend.size()-1];
        mo_cnt = pend.size(); mo_sof = mf_sof; mo_eol = eol; mo_x = mf_x;
        mf_x = eol ? 0 : (mf_x + 1) % 256;
        pend.delete();
        mf_sof = 1'b0;
        mo_v = 1'b1;
      end else if (hs) mo_v = 1'b0;
    end else if (hs) mo_v = 1'b0;
  endtask

  task automatic check_outputs();
    check("m_valid", m_valid, mo_v);
    check("drop_pulse", drop_pulse, me_drop);
    if (mo_v) begin
      check("m_chunk", m_chunk, mo_chunk);
      check("m_count", m_count, mo_cnt);
      check("m_sof", m_sof, mo_sof);
      check("m_eol", m_eol, mo_eol);
      check("m_chunk_x", m_chunk_x, mo_x);
    end
  endtask

  // One clock: drive at negedge, check s_ready, advance model at the edge, check outputs after it.
  task automatic step(input logic v, input logic [PW-1:0] pix, input logic sof, input logic eol,
                      input logic mr, output logic acc);
    s_valid = v; s_pixel = pix; s_sof = sof; s_eol = eol; m_ready = mr;
    #1;
    check("s_ready", s_ready, !mo_v || mr);
    acc = v && s_ready;
    @(posedge clk);
    model_edge(acc, pix, sof, eol, mr);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic send(input logic [PW-1:0] pix, input logic sof, input logic eol);
    logic a;
    int n;
    n = 0;
    do begin
      step(1'b1, pix, sof, eol, 1'b1, a);
      n++;
    end while (!a && n < 50);
    if (!a) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: pixel %0h not accepted within 50 cycles", pix);
    end
  endtask

  task automatic idle();
    logic a;
    step(1'b0, {PW{1'b0}}, 1'b0, 1'b0, 1'b1, a);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_valid"}, m_valid, 1'b0);
    check({tag, "_s_ready"}, s_ready, 1'b0);
    check({tag, "_m_chunk"}, m_chunk, '0);
    check({tag, "_m_count"}, m_count, 4'd0);
    check({tag, "_m_sof_eol"}, {m_sof, m_eol, drop_pulse}, 3'b000);
    check({tag, "_m_chunk_x"}, m_chunk_x, 8'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic a;
    logic [PW*CS-1:0] e;
    int nxt, hold_acc;

    tbl[0] = '{1'b1, 24'h000100, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0, 24'h0, 24'h0};
    tbl[1] = '{1'b1, 24'h000101, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0, 24'h0, 24'h0};
    tbl[2] = '{1'b1, 24'h000102, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0, 24'h0, 24'h0};
    tbl[3] = '{1'b1, 24'h000103, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0, 24'h0, 24'h0};
    tbl[4] = '{1'b1, 24'h000104, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, 1'b1, 24'h0, 24'h0};
    tbl[5] = '{1'b1, 24'h000105, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 1'b1, 1'b1, 8'd0, 1'b0, 24'h000104, 24'h000105};
    tbl[6] = '{1'b1, 24'h000200, 1'b1, 1'b1, 1'b1, 1'b1, 4'd1, 1'b1, 1'b1, 8'd0, 1'b0, 24'h000200, 24'h000200};
    tbl[7] = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0, 24'h0, 24'h0};
    tbl[8] = '{1'b1, 24'h000300, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0, 24'h0, 24'h0};
    tbl[9] = '{1'b1, 24'h000301, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 1'b0, 1'b1, 8'd0, 1'b0, 24'h000300, 24'h000301};

    resetn = 1'b0; s_valid = 1'b0; s_pixel = '0; s_sof = 1'b0; s_eol = 1'b0; m_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;

    // 16-pixel line: two full chunks, one cycle latency after each 8th pixel.
    for (int p = 1; p <= 16; p++) begin
      send(24'(p), p == 1, p == 16);
      if (p == 7) check("A_latency", m_valid, 1'b0);
      if (p == 8) begin
        for (int i = 0; i < CS; i++) e[i*PW +: PW] = 24'(i + 1);
        check("A_chunk1", m_chunk, e);
        check("A_chunk1_meta", {m_valid, m_count, m_sof, m_eol, m_chunk_x}, {1'b1, 4'd8, 1'b1, 1'b0, 8'd0});
      end
      if (p == 16) begin
        for (int i = 0; i < CS; i++) e[i*PW +: PW] = 24'(i + 9);
        check("A_chunk2", m_chunk, e);
        check("A_chunk2_meta", {m_valid, m_count, m_sof, m_eol, m_chunk_x}, {1'b1, 4'd8, 1'b0, 1'b1, 8'd1});
      end
    end

    // 11-pixel line: 3-pixel tail padded with the EOL pixel.
    for (int p = 0; p < 11; p++) send((p == 10) ? 24'hABCDEF : 24'(32'h20 + p), 1'b0, p == 10);
    check("B_count", m_count, 4'd3);
    check("B_x", m_chunk_x, 8'd1);
    check("B_lane0", m_chunk[0 +: PW], 24'h000028);
    check("B_lane1", m_chunk[PW +: PW], 24'h000029);
    for (int i = 2; i < CS; i++) check("B_pad_lane", m_chunk[i*PW +: PW], 24'hABCDEF);
    for (int p = 0; p < 8; p++) send(24'(32'h30 + p), 1'b0, 1'b0);
    check("B_next_line_x", m_chunk_x, 8'd0);
    send(24'h000038, 1'b0, 1'b1);
    check("B_tail_x", {m_count, m_chunk_x}, {4'd1, 8'd1});

    // Directed table: SOF on the 5th pixel, SOF+EOL single beat, short line.
    idle();
    for (int k = 0; k < 10; k++) begin
      step(tbl[k].v, tbl[k].pix, tbl[k].sof, tbl[k].eol, tbl[k].mr, a);
      check("tbl_m_valid", m_valid, tbl[k].ev);
      check("tbl_drop", drop_pulse, tbl[k].edrop);
      if (tbl[k].ev) begin
        check("tbl_meta", {m_count, m_sof, m_eol, m_chunk_x}, {tbl[k].ecnt, tbl[k].esof, tbl[k].eeol, tbl[k].ex});
        check("tbl_lane0", m_chunk[0 +: PW], tbl[k].el0);
        check("tbl_lane7", m_chunk[7*PW +: PW], tbl[k].el7);
      end
    end

    // Backpressure: m_ready low for 20 cycles with a continuous stream.
    idle();
    nxt = 0; hold_acc = 0;
    for (int cyc = 0; cyc < 80 && nxt < 24; cyc++) begin
      step(1'b1, 24'(32'h400 + nxt), nxt == 0, nxt == 23, cyc >= 20, a);
      if (a) begin
        nxt++;
        if (cyc < 20) hold_acc++;
      end
    end
    check("C_accepted_during_hold", hold_acc, 8);
    check("C_all_accepted", nxt, 24);
    idle();

    // Asynchronous reset while a chunk is held on the output.
    for (int p = 0; p < 8; p++) send(24'(32'h500 + p), p == 0, 1'b0);
    step(1'b1, 24'h000508, 1'b0, 1'b0, 1'b0, a);
    check("F_held_valid", m_valid, 1'b1);
    #2 resetn = 1'b0;
    #1;
    check_reset_outputs("F_reset");
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    for (int p = 0; p < 8; p++) send(24'(32'h600 + p), 1'b0, 1'b0);
    for (int i = 0; i < CS; i++) e[i*PW +: PW] = 24'(32'h600 + i);
    check("F_clean_chunk", m_chunk, e);
    check("F_clean_meta", {m_valid, m_count, m_sof, m_eol, m_chunk_x}, {1'b1, 4'd8, 1'b0, 1'b0, 8'd0});

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step($urandom_range(0, 3) != 0, 24'($urandom), $urandom_range(0, 29) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, a);
    end
    repeat (3) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_chunk_packer.md
Name: pixel_chunk_packer

Overview:
- Sits directly upstream of the resolution upscaler chunk stage.
- Accepts a serial pixel stream, one pixel per beat, with valid/ready handshake, start-of-frame and end-of-line markers.
- Packs consecutive pixels of a line into CHUNK_SIZE-wide chunks, presented on a registered valid/ready output that feeds the upscaler's chunk input.
- Pads line-end partial chunks by edge replication, and tags each chunk with a pixel count, its chunk index within the line, and SOF/EOL flags.

Parameters:
PIXEL_W, 24, bits per pixel (RGB888).
CHUNK_SIZE, 8, pixels per chunk. Must be 2 or more.
X_W, 8, width of the chunk-index-within-line counter.

Ports:
clk  input  1  single clock; all logic rising-edge.
resetn  input  1  asynchronous active-low reset.
s_pixel  input  PIXEL_W  input pixel.
s_valid  input  1  input beat valid.
s_ready  output  1  input beat accepted when s_valid && s_ready.
s_sof  input  1  beat is the first pixel of a frame.
s_eol  input  1  beat is the last pixel of a line.
m_chunk  output  PIXEL_W*CHUNK_SIZE  packed chunk. Lane i is at bits [i*PIXEL_W +: PIXEL_W]; lane 0 is the earliest pixel.
m_valid  output  1  chunk valid.
m_ready  input  1  downstream accepts chunk.
m_count  output  $clog2(CHUNK_SIZE+1)  number of real (non-padded) pixels, range 1..CHUNK_SIZE.
m_sof  output  1  chunk contains the frame's first pixel.
m_eol  output  1  chunk contains the line's last pixel.
m_chunk_x  output  X_W  chunk index within the current line.
drop_pulse  output  1  one-cycle pulse when a partial chunk is discarded.

Behaviour:
- Reset (resetn low, asynchronous):
  - m_valid, m_chunk, m_count, m_sof, m_eol, m_chunk_x and drop_pulse are 0.
  - Fill index idx = 0, line chunk counter = 0, accumulator cleared.
  - s_ready is 0 while resetn is low.
- Ready rule: s_ready = resetn && (!m_valid || m_ready). s_ready depends only on output-register state and m_ready, never on s_valid.
- Accept (s_valid && s_ready):
  - The pixel is written into accumulator lane idx.
  - If s_sof is set, the accumulator's sof flag is set.
- Completion: a chunk completes when the accepted beat has idx == CHUNK_SIZE-1 or s_eol == 1.
  - On the completing beat, the chunk loads the output register on that same edge:
    - m_chunk = accumulated lanes plus the current pixel.
    - m_count = idx+1.
    - m_sof = sof flag OR s_sof.
    - m_eol = s_eol.
    - m_chunk_x = line chunk counter.
  - m_valid = 1 from the next cycle. Latency from the last accepted pixel to m_valid is 1 cycle.
  - After completion, idx returns to 0 and the sof flag is cleared.
  - Line chunk counter: cleared to 0 if s_eol, otherwise incremented. It wraps modulo 2^X_W.
- Non-completing beat: idx increments; the output register is untouched.
- Padding: on an s_eol completion with idx < CHUNK_SIZE-1, lanes idx+1..CHUNK_SIZE-1 of m_chunk all equal the s_eol pixel.
- Output register:
  - Holds its value while m_valid && !m_ready.
  - m_valid is cleared on m_valid && m_ready unless a new chunk loads on the same edge; in that case m_valid stays 1 with the new contents.
  - Sustained throughput is one pixel per cycle.
- SOF mid-chunk (accepted beat with s_sof and idx != 0):
  - The pending partial pixels are discarded and drop_pulse = 1 for one cycle.
  - The SOF pixel is written to lane 0 and idx becomes 1, or the chunk completes immediately if CHUNK_SIZE==1 or s_eol is also set.
  - The line chunk counter is reset to 0 before use.
- SOF at idx == 0 also resets the line chunk counter to 0 and does not pulse drop_pulse.
- A single beat with both s_sof and s_eol completes a 1-pixel chunk with m_sof = m_eol = 1 and m_count = 1.
- Reset mid-operation: any partial chunk and any held output chunk are lost; there is no flush.
- Backpressure never drops data. Pixels are only lost through the SOF-mid-chunk rule.

Test Plan:
- CHUNK_SIZE=8. Stream 16 pixels 0x000001..0x000010, SOF on the first, EOL on the last, m_ready=1 → two chunks:
  - Chunk 1: lanes 1..8, m_count=8, m_chunk_x=0, m_sof=1, m_eol=0.
  - Chunk 2: lanes 9..16, m_chunk_x=1, m_sof=0, m_eol=1.
  - Each m_valid asserts 1 cycle after its 8th pixel.
- 11-pixel line, EOL on the 11th (value 0xABCDEF) → second chunk has m_count=3 and lanes 3..7 all 0xABCDEF; m_chunk_x resets to 0 for the next line.
- Hold m_ready=0 for 20 cycles while streaming continuously → s_ready drops on the cycle after the first chunk completes; no pixel is lost or duplicated; the stream resumes once m_ready=1.
- SOF asserted on the 5th pixel of a chunk → drop_pulse for one cycle; the next emitted chunk starts with the SOF pixel in lane 0, with m_sof=1 and m_chunk_x=0.
- A single beat with SOF+EOL → m_count=1, m_sof=1, m_eol=1, all lanes equal that pixel.
- Assert resetn low mid-chunk with m_valid=1 → m_valid=0 and s_ready=0 immediately; after release, the first 8 pixels form a clean chunk with m_chunk_x=0.
